// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game sequencer: button conditioning, gravity, landing/clear/game-over FSM
// Optional pause on btn_start while in MOVE is compiled in with `define PAUSE_EN.
module game_ctrl #(
    parameter int DROP_TICKS   = 16,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic        clka,
    input  logic        restart_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rotate,
    input  logic        btn_start,
    input  logic        touched,
    input  logic        error_in,
    input  logic [31:0] board_in,
    output logic [3:0]  state,
    output logic [1:0]  move,
    output logic        drop,
    output logic [7:0]  pieces,
    output logic        paused
);

    localparam int GW = $clog2(DROP_TICKS);
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_ROT   = 2;
    localparam int B_START = 3;

    localparam logic [1:0] MV_LEFT   = 2'd0;
    localparam logic [1:0] MV_RIGHT  = 2'd1;
    localparam logic [1:0] MV_ROTATE = 2'd2;
    localparam logic [1:0] MV_IDLE   = 2'd3;

    typedef enum logic [3:0] {
        S_GEN      = 4'd0,
        S_MOVE     = 4'd1,
        S_LAND     = 4'd2,
        S_CLEAR    = 4'd3,
        S_NEWBOARD = 4'd4,
        S_GAMEOVER = 4'd5
    } state_t;

    state_t        cur, nxt;
    logic [1:0]    move_nxt;
    logic          drop_nxt;
    logic [7:0]    pieces_nxt;
    logic [GW-1:0] grav_cnt, grav_nxt;
    logic [CW-1:0] clr_cnt, clr_nxt;
    logic          pause_act;

    logic [3:0] btn_raw;
    logic [3:0] sync1, sync2, sync3;
    logic [3:0] edge_q;

    // Only the top row of the board decides game over.
    logic unused_board;
    assign unused_board = ^board_in[31:4];

    assign btn_raw = {btn_start, btn_rotate, btn_right, btn_left};
    assign state   = cur;

    // Edge pulses are registered so every consumer sees a clean one-cycle strobe.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

`ifdef PAUSE_EN
    logic paused_q, paused_nxt;

    always_comb begin
        paused_nxt = paused_q;
        if (cur == S_MOVE && edge_q[B_START]) begin
            paused_nxt = ~paused_q;
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            paused_q <= 1'b0;
        end else begin
            paused_q <= paused_nxt;
        end
    end

    assign pause_act = paused_q;
    assign paused    = paused_q;
`else
    assign pause_act = 1'b0;
    assign paused    = 1'b0;
`endif

    always_comb begin
        nxt        = cur;
        move_nxt   = MV_IDLE;
        drop_nxt   = 1'b0;
        pieces_nxt = pieces;
        grav_nxt   = grav_cnt;
        clr_nxt    = clr_cnt;
        case (cur)
            S_NEWBOARD: begin
                if (edge_q[B_START]) begin
                    nxt = S_GEN;
                end
            end
            S_GEN: begin
                nxt      = S_MOVE;
                grav_nxt = '0;
            end
            S_MOVE: begin
                if (!pause_act) begin
                    if (touched) begin
                        nxt = S_LAND;
                    end
                    if (edge_q[B_ROT]) begin
                        move_nxt = MV_ROTATE;
                    end else if (edge_q[B_LEFT]) begin
                        move_nxt = MV_LEFT;
                    end else if (edge_q[B_RIGHT]) begin
                        move_nxt = MV_RIGHT;
                    end
                    // A wrap on the landing cycle is not shown, so drop never lands in LAND.
                    if (grav_cnt == GW'(DROP_TICKS - 1)) begin
                        grav_nxt = '0;
                        drop_nxt = ~touched;
                    end else begin
                        grav_nxt = grav_cnt + GW'(1);
                    end
                end
            end
            S_LAND: begin
                nxt     = S_CLEAR;
                clr_nxt = '0;
                if (pieces != 8'hFF) begin
                    pieces_nxt = pieces + 8'd1;
                end
            end
            S_CLEAR: begin
                if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                    if (error_in || (board_in[3:0] != 4'd0)) begin
                        nxt = S_GAMEOVER;
                    end else begin
                        nxt = S_GEN;
                    end
                end else begin
                    clr_nxt = clr_cnt + CW'(1);
                end
            end
            S_GAMEOVER: begin
                if (edge_q[B_START]) begin
                    nxt        = S_NEWBOARD;
                    pieces_nxt = 8'd0;
                end
            end
            default: begin
                nxt = S_NEWBOARD;
            end
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            cur      <= S_NEWBOARD;
            move     <= MV_IDLE;
            drop     <= 1'b0;
            pieces   <= 8'd0;
            grav_cnt <= '0;
            clr_cnt  <= '0;
        end else begin
            cur      <= nxt;
            move     <= move_nxt;
            drop     <= drop_nxt;
            pieces   <= pieces_nxt;
            grav_cnt <= grav_nxt;
            clr_cnt  <= clr_nxt;
        end
    end

endmodule
